// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
//   Request/response bundle between the load/store unit (master) and the
//   data-memory responder (slave).
//   Request : req_valid, req_ready, req_write, req_addr, req_wdata, req_be
//   Response: resp_valid (one-cycle pulse), resp_rdata, resp_fault
// -----------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the LSU. Accepts one word-aligned request at a
//   time, waits WAIT_CYCLES, performs a byte-masked write or a full-word read
//   of the internal array and returns a registered one-cycle response with
//   read data and an access-fault flag. Optionally hosts the console print
//   register at PRINT_ADDR.
//
//   Ports:
//     clk        - clock, all state on rising edge
//     start      - asynchronous active-low reset
//     bus        - dmem_responder_if.slave (request/response handshake)
//     print_en   - one-cycle pulse, coincident with the print store response
//     print_data - last printed word, held until the next print
//
//   Build option:
//     DMEM_PRINT_EN - when defined, the print register exists; otherwise
//                     PRINT_ADDR decodes as an ordinary out-of-range address
//                     and print_en/print_data are tied to zero.
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
  parameter int unsigned MEM_WORDS   = 4096,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] PRINT_ADDR  = 32'hFFFF_FFF0
) (
  input  logic             clk,
  input  logic             start,
  dmem_responder_if.slave  bus,
  output logic             print_en,
  output logic [31:0]      print_data
);

  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  if ((MEM_WORDS < 2) || ((MEM_WORDS & (MEM_WORDS - 1)) != 0)) begin : g_words_check
    $error("MEM_WORDS must be a power of two >= 2");
  end
  if (PRINT_ADDR[1:0] != 2'b00) begin : g_print_addr_check
    $error("PRINT_ADDR must be word-aligned");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               write_q, write_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               fault_q, fault_d;
  logic               print_q, print_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [31:0]        mem [MEM_WORDS];
  logic               mem_we;

  // ---------------------------------------------------------------------------
  // Request decode (live request, used at accept time)
  // ---------------------------------------------------------------------------
  logic [31:0]      req_off;
  logic             req_in_range;
  logic             req_print;
  logic             req_fault;
  logic [IDX_W-1:0] req_idx;
  logic             accept;

  assign req_off = bus.req_addr - MEM_BASE;
  // An address below MEM_BASE wraps to a large offset, so a single unsigned
  // compare covers both ends of the window.
  assign req_in_range = ({1'b0, req_off} < MEM_BYTES);
  assign req_idx      = req_off[IDX_W+1:2];

`ifdef DMEM_PRINT_EN
  assign req_print = (bus.req_addr == PRINT_ADDR);
`else
  assign req_print = 1'b0;
`endif

  assign req_fault = (bus.req_addr[1:0] != 2'b00)
                  || (bus.req_be == 4'b0000)
                  || (!req_in_range && !req_print)
                  || (req_print && bus.req_write && (bus.req_be != 4'b1111));

  assign accept = bus.req_valid && ready_q;

  // With WAIT_CYCLES=0 the RESP-entry edge is the accept edge itself, so the
  // access uses the live request then; otherwise it uses the latched copy.
  logic             sel_live;
  logic             op_write;
  logic             op_fault;
  logic             op_print;
  logic [3:0]       op_be;
  logic [31:0]      op_wdata;
  logic [IDX_W-1:0] op_idx;

  assign sel_live = (state_q == IDLE);
  assign op_write = sel_live ? bus.req_write : write_q;
  assign op_fault = sel_live ? req_fault     : fault_q;
  assign op_print = sel_live ? req_print     : print_q;
  assign op_be    = sel_live ? bus.req_be    : be_q;
  assign op_wdata = sel_live ? bus.req_wdata : wdata_q;
  assign op_idx   = sel_live ? req_idx       : idx_q;

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    fault_d = fault_q;
    print_d = print_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d = bus.req_write;
          be_d    = bus.req_be;
          wdata_d = bus.req_wdata;
          idx_d   = req_idx;
          fault_d = req_fault;
          print_d = req_print;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);

    if (state_d == RESP) begin
      mem_we  = op_write && !op_fault && !op_print;
      rdata_d = (op_write || op_fault || op_print) ? '0 : mem[op_idx];
    end
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      write_q <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      fault_q <= 1'b0;
      print_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      write_q <= write_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      fault_q <= fault_d;
      print_q <= print_d;
      rdata_q <= rdata_d;
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (op_be[i]) mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_fault = (state_q == RESP) && fault_q;
  assign bus.resp_rdata = rdata_q;

  // ---------------------------------------------------------------------------
  // Console print register
  // ---------------------------------------------------------------------------
`ifdef DMEM_PRINT_EN
  logic [31:0] print_data_q, print_data_d;

  always_comb begin
    print_data_d = print_data_q;
    if ((state_d == RESP) && op_print && op_write && !op_fault) print_data_d = op_wdata;
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) print_data_q <= '0;
    else        print_data_q <= print_data_d;
  end

  assign print_en   = (state_q == RESP) && print_q && write_q && !fault_q;
  assign print_data = print_data_q;
`else
  assign print_en   = 1'b0;
  assign print_data = '0;
`endif

endmodule
